rs_issue_scheduler: RTL
=======================

Name: rs_issue_scheduler

Overview:
- Oldest-first issue scheduler for the 16-row reservation station.
- Tracks which RS rows hold un-issued instructions, plus their relative age and FU class.
- Each cycle, picks up to 3 ready rows: two for the ALUs (FU0, FU1) and one for the MEM/MUL unit (FU2).
- Grants are registered, and the RS uses them to read out and free the issued rows.

Parameters:
- NUM_ROWS, 16, RS depth. The scheduler tracks one entry per RS row.
- IDX_W, 4, row index width; equals log2(NUM_ROWS).

Ports:
- i_clk  in  1  clock, rising edge
- i_rst  in  1  synchronous active-high reset
- i_flush  in  1  discard all pending rows (mispredict)
- i_alloc_valid  in  2  slot k writes row i_alloc_idx[k] this cycle; slot 0 is older than slot 1
- i_alloc_idx  in  2xIDX_W  RS row written by each alloc slot
- i_alloc_class  in  2  per slot: 0 = ALU, 1 = MEM/MUL
- i_row_ready  in  NUM_ROWS  all source operands of row i are available (from RS wakeup)
- i_fu_ready  in  3  FU0/FU1 (ALU) and FU2 (MEM/MUL) can accept an instruction next cycle
- o_issue_valid  out  3  per-FU issue strobe, registered
- o_issue_idx  out  3xIDX_W  RS row issued to each FU, registered
- o_row_clear  out  NUM_ROWS  one-hot-per-issue mask of rows freed this cycle; equals the OR of issued rows
- o_pending  out  NUM_ROWS  rows allocated but not yet issued
- o_alloc_err  out  1  pulse: an alloc targeted a row that is already pending, or both slots named the same row

Behaviour:
- Reset (i_rst high at an edge):
  - pending, class, age matrix and all outputs clear to 0.
  - o_issue_idx resets to 0.
  - Reset mid-operation drops everything in flight; no issue occurs in the cycle after reset.
- Per-row state: pending bit, class bit, and age matrix older[i][j] (i is older than j).
- Allocation (edge at end of cycle t):
  - For each valid slot k writing row r: pending[r] <= 1, class[r] <= i_alloc_class[k].
  - older[j][r] <= 1 for every j that is already pending; older[r][*] <= 0.
  - If both slots allocate, slot 0's row is marked older than slot 1's row.
  - An allocated row becomes eligible at the earliest in cycle t+1 (i_row_ready is sampled only for rows pending at the start of the cycle).
- Alloc errors:
  - Alloc to a row that is already pending, or both slots naming the same index: that slot is ignored and o_alloc_err pulses for 1 cycle.
  - Row state is unchanged.
- Eligibility: eligible[i] = pending[i] & i_row_ready[i] & ~i_flush.
- ALU selection (class 0):
  - A = the oldest eligible ALU row; B = the second-oldest.
  - Oldest means no other eligible ALU row is older.
  - If both FU0 and FU1 are ready: A goes to FU0, B to FU1.
  - If only one ALU FU is ready: A goes to that FU.
- MEM/MUL selection (class 1): the oldest eligible class-1 row goes to FU2 when i_fu_ready[2] is high.
- Issue latency:
  - Selection is combinational in cycle t and registered at the edge.
  - o_issue_valid, o_issue_idx and o_row_clear are valid in cycle t+1.
  - At the same edge, pending[issued rows] <= 0, so a row is never issued twice.
  - An FU with nothing eligible or not ready gets o_issue_valid = 0, and its o_issue_idx holds its previous value.
- Simultaneous alloc and issue: these are always on different rows, because an allocated row is not pending and therefore not eligible. Both take effect at the same edge.
- Flush:
  - i_flush high at an edge: all pending <= 0 and no issue is registered, so outputs are 0 in the next cycle.
  - Allocations in the flush cycle are discarded.
  - Grants registered before the flush edge are still presented.
- Full and empty:
  - When all 16 rows are pending, further allocs raise o_alloc_err. The RS must stall allocation using o_pending.
  - When empty, all issue outputs are 0.
- At most 3 issues per cycle. o_row_clear has at most 3 bits set.

Test Plan:
- Reset with i_fu_ready = 3'b111 and all rows ready -> o_issue_valid = 0, o_pending = 0, o_issue_idx = 0 for 2 cycles after reset release.
- Alloc ALU rows 5 then 2 (2 in a later cycle), rows 2 and 5 both ready, all FUs ready -> next cycle o_issue_idx[0] = 5, o_issue_idx[1] = 2, o_row_clear = 0x0024, o_pending = 0.
- Alloc ALU rows 3, 7, 9 in order, all ready, only i_fu_ready[1] = 1 -> row 3 goes to FU1 first, then row 7, then row 9 on successive cycles; FU0 stays idle.
- Same-cycle alloc of slot 0 = row 4 (MEM), slot 1 = row 1 (MEM), both ready, FU2 ready -> row 4 issues on FU2 first, row 1 in the following cycle; row 4 is not eligible until the cycle after alloc.
- Alloc rows 0–15, then alloc row 6 again -> o_alloc_err = 1 for 1 cycle and row 6's class is unchanged. Then i_flush -> o_pending = 0 next cycle and no issues.
- Row 8 pending but i_row_ready[8] held 0 for 10 cycles, then 1 -> issue appears exactly 1 cycle after ready rises; never issued while not ready.

Source files
------------

// File: rtl/rs_issue_scheduler_if.sv
// Handshake bundle between the reservation station and its issue scheduler.
// The RS side drives allocation, wakeup and FU-ready; the scheduler returns
// registered grants, the freed-row mask, the pending map and the alloc error.
interface rs_issue_scheduler_if #(
    parameter int NUM_ROWS = 16,
    parameter int IDX_W    = 4
);
    logic                      i_flush;
    logic [1:0]                i_alloc_valid;
    logic [1:0][IDX_W-1:0]     i_alloc_idx;
    logic [1:0]                i_alloc_class;
    logic [NUM_ROWS-1:0]       i_row_ready;
    logic [2:0]                i_fu_ready;
    logic [2:0]                o_issue_valid;
    logic [2:0][IDX_W-1:0]     o_issue_idx;
    logic [NUM_ROWS-1:0]       o_row_clear;
    logic [NUM_ROWS-1:0]       o_pending;
    logic                      o_alloc_err;

    modport master (
        output i_flush, i_alloc_valid, i_alloc_idx, i_alloc_class,
               i_row_ready, i_fu_ready,
        input  o_issue_valid, o_issue_idx, o_row_clear, o_pending, o_alloc_err
    );

    modport slave (
        input  i_flush, i_alloc_valid, i_alloc_idx, i_alloc_class,
               i_row_ready, i_fu_ready,
        output o_issue_valid, o_issue_idx, o_row_clear, o_pending, o_alloc_err
    );
endinterface

// File: rtl/rs_issue_scheduler.sv
// Oldest-first issue scheduler for a 16-row reservation station.
// Keeps a pending bit, an FU-class bit and a pairwise age matrix per row, and
// each cycle grants up to two ALU rows (FU0/FU1) and one MEM/MUL row (FU2).
// Grants are registered; issued rows leave the pending set at the same edge.
module rs_issue_scheduler #(
    parameter int NUM_ROWS = 16,
    parameter int IDX_W    = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    rs_issue_scheduler_if.slave   bus
);

    // older_q[i][j] = 1 means row i was allocated before row j.
    logic [NUM_ROWS-1:0]          pending_q;
    logic [NUM_ROWS-1:0]          class_q;
    logic [NUM_ROWS-1:0]          older_q [NUM_ROWS];

    logic [2:0]                   issue_valid_q;
    logic [2:0][IDX_W-1:0]        issue_idx_q;
    logic [NUM_ROWS-1:0]          row_clear_q;
    logic                         alloc_err_q;

    // col[i][j] = older_q[j][i]: the set of rows older than row i.
    logic [NUM_ROWS-1:0][NUM_ROWS-1:0] older_col;

    logic                         same_idx;
    logic                         ok0, ok1;
    logic                         alloc_err_d;
    logic [NUM_ROWS-1:0]          alloc_mask;

    logic [NUM_ROWS-1:0]          elig, elig_alu, elig_mem;
    logic [NUM_ROWS-1:0]          sel_a, sel_b, sel_m;

    logic [2:0]                   grant_v;
    logic [2:0][IDX_W-1:0]        grant_idx;
    logic [NUM_ROWS-1:0]          grant_mask;

    // Candidate rows that have no older candidate; the age order is total over
    // pending rows, so at most one bit survives.
    function automatic logic [NUM_ROWS-1:0] oldest_of(
        input logic [NUM_ROWS-1:0]                cand,
        input logic [NUM_ROWS-1:0][NUM_ROWS-1:0]  col
    );
        logic [NUM_ROWS-1:0] res;
        res = '0;
        for (int i = 0; i < NUM_ROWS; i++) begin
            res[i] = cand[i] & ~(|(cand & col[i]));
        end
        return res;
    endfunction

    function automatic logic [IDX_W-1:0] encode(input logic [NUM_ROWS-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_ROWS; i++) begin
            if (oh[i]) idx = idx | IDX_W'(i);
        end
        return idx;
    endfunction

    // Transpose the age matrix so each row sees its "older than me" set.
    always_comb begin
        for (int i = 0; i < NUM_ROWS; i++) begin
            for (int j = 0; j < NUM_ROWS; j++) begin
                older_col[i][j] = older_q[j][i];
            end
        end
    end

    // Allocation checks: a slot hitting a pending row, or slot 1 repeating
    // slot 0's row, is dropped and flagged; flush discards every allocation.
    always_comb begin
        same_idx    = bus.i_alloc_valid[0] & bus.i_alloc_valid[1] &
                      (bus.i_alloc_idx[0] == bus.i_alloc_idx[1]);
        alloc_err_d = (bus.i_alloc_valid[0] & pending_q[bus.i_alloc_idx[0]]) |
                      (bus.i_alloc_valid[1] & (pending_q[bus.i_alloc_idx[1]] | same_idx));
        ok0         = bus.i_alloc_valid[0] & ~pending_q[bus.i_alloc_idx[0]] & ~bus.i_flush;
        ok1         = bus.i_alloc_valid[1] & ~pending_q[bus.i_alloc_idx[1]] & ~same_idx &
                      ~bus.i_flush;
        alloc_mask  = '0;
        if (ok0) alloc_mask = alloc_mask | (NUM_ROWS'(1) << bus.i_alloc_idx[0]);
        if (ok1) alloc_mask = alloc_mask | (NUM_ROWS'(1) << bus.i_alloc_idx[1]);
    end

    // Oldest-first selection and mapping of picks onto the ready FUs.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        grant_v    = '0;
        grant_idx  = issue_idx_q;
        grant_mask = '0;

        elig     = pending_q & bus.i_row_ready & {NUM_ROWS{~bus.i_flush}};
        elig_alu = elig & ~class_q;
        elig_mem = elig & class_q;
        sel_a    = oldest_of(elig_alu, older_col);
        sel_b    = oldest_of(elig_alu & ~sel_a, older_col);
        sel_m    = oldest_of(elig_mem, older_col);

        if (bus.i_fu_ready[0]) begin
            if (|sel_a) begin
                grant_v[0]   = 1'b1;
                grant_idx[0] = encode(sel_a);
                grant_mask   = grant_mask | sel_a;
            end
            if (bus.i_fu_ready[1] && (|sel_b)) begin
                grant_v[1]   = 1'b1;
                grant_idx[1] = encode(sel_b);
                grant_mask   = grant_mask | sel_b;
            end
        end else if (bus.i_fu_ready[1] && (|sel_a)) begin
            grant_v[1]   = 1'b1;
            grant_idx[1] = encode(sel_a);
            grant_mask   = grant_mask | sel_a;
        end

        if (bus.i_fu_ready[2] && (|sel_m)) begin
            grant_v[2]   = 1'b1;
            grant_idx[2] = encode(sel_m);
            grant_mask   = grant_mask | sel_m;
        end
    end

    // Row state, age matrix and registered grant outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            // NOTE: the age matrix is control state, not a data RAM, so it is reset like any flop.
            pending_q     <= '0;
            class_q       <= '0;
            for (int i = 0; i < NUM_ROWS; i++) older_q[i] <= '0;
            issue_valid_q <= '0;
            issue_idx_q   <= '0;
            row_clear_q   <= '0;
            alloc_err_q   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments; later writes in this block win.
            issue_valid_q <= grant_v;
            issue_idx_q   <= grant_idx;
            row_clear_q   <= grant_mask;
            alloc_err_q   <= alloc_err_d;

            if (bus.i_flush) pending_q <= '0;
            else             pending_q <= (pending_q & ~grant_mask) | alloc_mask;

            if (ok0) begin
                class_q[bus.i_alloc_idx[0]] <= bus.i_alloc_class[0];
                older_q[bus.i_alloc_idx[0]] <= '0;
            end
            if (ok1) begin
                class_q[bus.i_alloc_idx[1]] <= bus.i_alloc_class[1];
                older_q[bus.i_alloc_idx[1]] <= '0;
            end
            // Column writes come after the row clears so slot 0 older-than slot 1 sticks.
            for (int j = 0; j < NUM_ROWS; j++) begin
                if (ok0) older_q[j][bus.i_alloc_idx[0]] <= pending_q[j];
                if (ok1) older_q[j][bus.i_alloc_idx[1]] <= pending_q[j] |
                         (ok0 && (IDX_W'(j) == bus.i_alloc_idx[0]));
            end
        end
    end

    assign bus.o_issue_valid = issue_valid_q;
    assign bus.o_issue_idx   = issue_idx_q;
    assign bus.o_row_clear   = row_clear_q;
    assign bus.o_pending     = pending_q;
    assign bus.o_alloc_err   = alloc_err_q;

endmodule
